// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline register: bus widths, stall-bit
// indices, reset polarity and the classification of each clock edge into the
// action the register stage takes.
package ex_mem_pkg;

  localparam int REG_W       = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int DREG_W      = 2 * REG_W;

  typedef logic [REG_W-1:0]      RegBus;
  typedef logic [REG_ADDR_W-1:0] RegAddrBus;
  typedef logic [DREG_W-1:0]     DoubleRegBus;

  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic RstEnable = 1'b0;

  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  // What the register stage does on a given (non-reset) clock edge.
  typedef enum logic [1:0] {
    MODE_CLEAR   = 2'd0,  // flush: drop the held instruction and any MAC state
    MODE_BUBBLE  = 2'd1,  // ex stalled, mem running: send NOP, capture MAC feedback
    MODE_ADVANCE = 2'd2,  // ex running: pass the instruction on to mem
    MODE_HOLD    = 2'd3   // mem stalled (or illegal stall combo): freeze everything
  } stage_mode_e;

  // Flush wins over any stall. The illegal combination "mem stalled while ex
  // runs" falls through to hold so an upstream glitch never corrupts mem.
  function automatic stage_mode_e classify_edge(input logic flush,
                                                input logic stall_ex,
                                                input logic stall_mem);
    stage_mode_e mode;
    if (flush) begin
      mode = MODE_CLEAR;
    end else if (stall_ex == Stop && stall_mem == NoStop) begin
      mode = MODE_BUBBLE;
    end else if (stall_ex == NoStop && stall_mem == NoStop) begin
      mode = MODE_ADVANCE;
    end else begin
      mode = MODE_HOLD;
    end
    return mode;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register of the five-stage MIPS core.
// Latches the GPR and HI/LO write requests from execute, honours the stall
// vector and flush, and (when EX_MEM_MADD_EN is defined) keeps the partial
// multiply-accumulate product and step count that execute feeds back to
// itself while it stalls. With EX_MEM_MADD_EN undefined the feedback outputs
// are constant zero and carry no flops; the ports stay for wiring stability.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [2*DATA_W-1:0]   hilo_temp_i,
  input  logic [1:0]            cnt_i,
  output logic [ADDR_W-1:0]     mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [1:0]            cnt_o
);

  stage_mode_e mode;

  logic [ADDR_W-1:0] mem_wd_d,    mem_wd_q;
  logic              mem_wreg_d,  mem_wreg_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic [DATA_W-1:0] mem_hi_d,    mem_hi_q;
  logic [DATA_W-1:0] mem_lo_d,    mem_lo_q;
  logic              mem_whilo_d, mem_whilo_q;

  // Only the ex and mem stall bits matter to this stage; the rest of the
  // vector is consumed elsewhere in the pipeline.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall;

  // Decode the edge action from flush and the two relevant stall bits.
  always_comb begin
    mode = classify_edge(flush, stall[STALL_EX], stall[STALL_MEM]);
  end

  // Next value of the mem-bound write request.
  always_comb begin
    mem_wd_d    = mem_wd_q;
    mem_wreg_d  = mem_wreg_q;
    mem_wdata_d = mem_wdata_q;
    mem_hi_d    = mem_hi_q;
    mem_lo_d    = mem_lo_q;
    mem_whilo_d = mem_whilo_q;
    case (mode)
      MODE_CLEAR, MODE_BUBBLE: begin
        mem_wd_d    = '0;
        mem_wreg_d  = 1'b0;
        mem_wdata_d = '0;
        mem_hi_d    = '0;
        mem_lo_d    = '0;
        mem_whilo_d = 1'b0;
      end
      MODE_ADVANCE: begin
        mem_wd_d    = ex_wd;
        mem_wreg_d  = ex_wreg;
        mem_wdata_d = ex_wdata;
        mem_hi_d    = ex_hi;
        mem_lo_d    = ex_lo;
        mem_whilo_d = ex_whilo;
      end
      default: begin
      end
    endcase
  end

  // Mem-bound write request register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      mem_wd_q    <= '0;
      mem_wreg_q  <= 1'b0;
      mem_wdata_q <= '0;
      mem_hi_q    <= '0;
      mem_lo_q    <= '0;
      mem_whilo_q <= 1'b0;
    end else begin
      mem_wd_q    <= mem_wd_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_wdata_q <= mem_wdata_d;
      mem_hi_q    <= mem_hi_d;
      mem_lo_q    <= mem_lo_d;
      mem_whilo_q <= mem_whilo_d;
    end
  end

  assign mem_wd    = mem_wd_q;
  assign mem_wreg  = mem_wreg_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_hi    = mem_hi_q;
  assign mem_lo    = mem_lo_q;
  assign mem_whilo = mem_whilo_q;

`ifdef EX_MEM_MADD_EN
  logic [2*DATA_W-1:0] hilo_temp_d, hilo_temp_q;
  logic [1:0]          cnt_d,       cnt_q;

  // MAC feedback: captured only on a bubble, cleared when execute advances
  // so the next MADD/MSUB starts from step 0.
  always_comb begin
    hilo_temp_d = hilo_temp_q;
    cnt_d       = cnt_q;
    case (mode)
      MODE_CLEAR, MODE_ADVANCE: begin
        hilo_temp_d = '0;
        cnt_d       = 2'd0;
      end
      MODE_BUBBLE: begin
        hilo_temp_d = hilo_temp_i;
        cnt_d       = cnt_i;
      end
      default: begin
      end
    endcase
  end

  // MAC feedback register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hilo_temp_q <= '0;
      cnt_q       <= 2'd0;
    end else begin
      hilo_temp_q <= hilo_temp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign hilo_temp_o = hilo_temp_q;
  assign cnt_o       = cnt_q;
`else
  // Without multiply-accumulate support the feedback path is constant zero.
  logic unused_mac_inputs;
  assign unused_mac_inputs = ^{hilo_temp_i, cnt_i};

  assign hilo_temp_o = '0;
  assign cnt_o       = 2'd0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed steps from the block's test plan
// followed by randomized stall/flush/reset traffic compared against a
// rule-level reference model. Follows EX_MEM_MADD_EN the same way the design does.
module tb_ex_mem;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int STALL_W = 6;

`ifdef EX_MEM_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic [STALL_W-1:0]  stall;
  logic                flush;
  logic [ADDR_W-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic                ex_whilo;
  logic [2*DATA_W-1:0] hilo_temp_i;
  logic [1:0]          cnt_i;
  logic [ADDR_W-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic                mem_whilo;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [1:0]          cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: what each output should read after the last edge.
  logic [ADDR_W-1:0]   m_wd;
  logic                m_wreg;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W-1:0]   m_hi;
  logic [DATA_W-1:0]   m_lo;
  logic                m_whilo;
  logic [2*DATA_W-1:0] m_temp;
  logic [1:0]          m_cnt;

  ex_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the operation rules to the inputs present at this edge.
  task automatic model_edge();
    bit ex_stalled, mem_stalled;
    ex_stalled  = stall[3];
    mem_stalled = stall[4];
    if (rst == 1'b0 || flush == 1'b1) begin
      {m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo} = '0;
      m_temp = '0;
      m_cnt  = '0;
    end else if (ex_stalled && !mem_stalled) begin
      {m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo} = '0;
      m_temp = MADD_EN ? hilo_temp_i : 64'd0;
      m_cnt  = MADD_EN ? cnt_i : 2'd0;
    end else if (!ex_stalled && !mem_stalled) begin
      m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata;
      m_hi = ex_hi; m_lo = ex_lo; m_whilo = ex_whilo;
      m_temp = '0;
      m_cnt  = '0;
    end
    // anything else is a hold: model state unchanged
  endtask

  task automatic check_all(input string tag);
    check({tag, ".mem_wd"},      64'(mem_wd),      64'(m_wd));
    check({tag, ".mem_wreg"},    64'(mem_wreg),    64'(m_wreg));
    check({tag, ".mem_wdata"},   64'(mem_wdata),   64'(m_wdata));
    check({tag, ".mem_hi"},      64'(mem_hi),      64'(m_hi));
    check({tag, ".mem_lo"},      64'(mem_lo),      64'(m_lo));
    check({tag, ".mem_whilo"},   64'(mem_whilo),   64'(m_whilo));
    check({tag, ".hilo_temp_o"}, hilo_temp_o,      m_temp);
    check({tag, ".cnt_o"},       64'(cnt_o),       64'(m_cnt));
  endtask

  // One clock edge: update the model, then sample 1ns after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic randomize_ex();
    ex_wd       = ADDR_W'($urandom);
    ex_wreg     = 1'($urandom);
    ex_wdata    = $urandom;
    ex_hi       = $urandom;
    ex_lo       = $urandom;
    ex_whilo    = 1'($urandom);
    hilo_temp_i = {$urandom, $urandom};
    cnt_i       = 2'($urandom_range(0, 1));
  endtask

  logic [STALL_W-1:0] stall_pick [7];

  initial begin
    stall_pick[0] = 6'b000000; stall_pick[1] = 6'b000011;
    stall_pick[2] = 6'b000111; stall_pick[3] = 6'b001111;
    stall_pick[4] = 6'b011111; stall_pick[5] = 6'b111111;
    stall_pick[6] = 6'b010000;

    flush = 1'b0; stall = '0; rst = 1'b1;
    randomize_ex();
    {m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo} = '0;
    m_temp = '0; m_cnt = '0;

    // Reset with a live write request present.
    @(negedge clk);
    rst = 1'b0; ex_wdata = 32'hDEADBEEF; ex_wreg = 1'b1;
    step("reset");
    check("reset.wdata_const", 64'(mem_wdata), 64'd0);
    rst = 1'b1;

    // Advance.
    stall = 6'b000000; ex_wd = 5'd8; ex_wdata = 32'h12345678; ex_wreg = 1'b1;
    step("advance");
    check("advance.wd_const",    64'(mem_wd),    64'd8);
    check("advance.wdata_const", 64'(mem_wdata), 64'h12345678);
    check("advance.cnt_const",   64'(cnt_o),     64'd0);

    // Bubble with a pending MAC partial product.
    stall = 6'b001111; hilo_temp_i = 64'h0000_0001_FFFF_FFFE; cnt_i = 2'd1; ex_wreg = 1'b1;
    step("bubble");
    check("bubble.wreg_const", 64'(mem_wreg), 64'd0);
    check("bubble.temp_const", hilo_temp_o, MADD_EN ? 64'h0000_0001_FFFF_FFFE : 64'd0);
    check("bubble.cnt_const",  64'(cnt_o),  MADD_EN ? 64'd1 : 64'd0);

    // Hold: load HI/LO write, then freeze for three cycles under changing inputs.
    stall = 6'b000000; ex_hi = 32'hA5A5A5A5; ex_whilo = 1'b1;
    step("hold_load");
    for (int i = 0; i < 3; i++) begin
      stall = 6'b011111;
      randomize_ex();
      step("hold");
      check("hold.hi_const",    64'(mem_hi),    64'hA5A5A5A5);
      check("hold.whilo_const", 64'(mem_whilo), 64'd1);
    end

    // Flush together with a bubble clears everything, MAC state included.
    stall = 6'b001111; cnt_i = 2'd1; hilo_temp_i = 64'h1234_5678_9ABC_DEF0;
    step("pre_flush_bubble");
    flush = 1'b1; ex_wreg = 1'b1;
    step("flush_bubble");
    check("flush.cnt_const", 64'(cnt_o), 64'd0);
    flush = 1'b0;

    // Illegal stall combination behaves as hold.
    stall = 6'b000000; randomize_ex();
    step("pre_illegal");
    stall = 6'b010000; randomize_ex();
    step("illegal_hold");

    // Randomized traffic, biased toward legal stall patterns.
    for (int i = 0; i < 300; i++) begin
      randomize_ex();
      stall = stall_pick[$urandom_range(0, 6)];
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 31) != 0);
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
